// File: rtl/st7785_pixel_stream.sv
// Streams one frame to an ST7785 over the 3-wire 9-bit serial link:
// CASET, RASET, RAMWR, then RGB565 pixels pulled through a valid/ready handshake.
module st7785_pixel_stream #(
   parameter int CLK_DIV = 6,
   parameter int H_RES   = 160,
   parameter int V_RES   = 144,
   parameter int X_START = 0,
   parameter int Y_START = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        init_done,
   input  logic        frame_start,
   input  logic [15:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        LCD_SCK,
   output logic        LCD_CS,
   output logic        LCD_SDA,
   output logic        busy,
   output logic        frame_done
);

   localparam int              TOTAL_PIX = H_RES * V_RES;
   localparam int              PCW       = $clog2(TOTAL_PIX + 1);
   localparam logic [7:0]      DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [8:0]      GAP_LAST  = 9'(2 * CLK_DIV - 1);
   localparam logic [15:0]     XS        = 16'(X_START);
   localparam logic [15:0]     XE        = 16'(X_START + H_RES - 1);
   localparam logic [15:0]     YS        = 16'(Y_START);
   localparam logic [15:0]     YE        = 16'(Y_START + V_RES - 1);
   localparam logic [PCW-1:0]  PIX_LAST  = PCW'(TOTAL_PIX);

   typedef enum logic [2:0] {
      S_IDLE, S_CASET, S_RASET, S_RAMWR, S_PIXELS, S_GAP
   } state_t;

   state_t           r_state, w_state_next;
   logic [7:0]       r_div, w_div_next;
   logic             r_phase, w_phase_next;
   logic [3:0]       r_bit, w_bit_next;
   logic [2:0]       r_widx, w_widx_next;
   logic             r_lo, w_lo_next;
   logic             r_gap, w_gap_next;
   logic [8:0]       r_gcnt, w_gcnt_next;
   logic             r_abort, w_abort_next;
   logic [15:0]      r_pix, w_pix_next;
   logic             r_have_pix, w_have_pix_next;
   logic             r_pix_ready, w_pix_ready_next;
   logic [PCW-1:0]   r_pix_cnt, w_pix_cnt_next;
   logic             r_cs, w_cs_next;
   logic             r_sck, w_sck_next;
   logic             r_sda, w_sda_next;
   logic             r_busy, w_busy_next;
   logic             r_frame_done, w_frame_done_next;

   logic             w_hs;
   logic             w_abort;
   logic             w_wait;
   state_t           w_grp_next;
   logic [8:0]       w_cur_word;
   logic [8:0]       w_next_word;
   logic [8:0]       w_first_word;

   // Nine-bit word for a given group/index; bit 8 is the D/C flag.
   function automatic logic [8:0] f_word(input state_t st, input logic [2:0] idx,
                                         input logic lo, input logic [15:0] px);
      logic [15:0] a;
      logic [15:0] b;
      logic [7:0]  cmd;
      a      = (st == S_CASET) ? XS : YS;
      b      = (st == S_CASET) ? XE : YE;
      cmd    = (st == S_CASET) ? 8'h2A : 8'h2B;
      f_word = 9'h000;
      case (st)
         S_CASET, S_RASET: begin
            case (idx)
               3'd0:    f_word = {1'b0, cmd};
               3'd1:    f_word = {1'b1, a[15:8]};
               3'd2:    f_word = {1'b1, a[7:0]};
               3'd3:    f_word = {1'b1, b[15:8]};
               default: f_word = {1'b1, b[7:0]};
            endcase
         end
         S_RAMWR:  f_word = {1'b0, 8'h2C};
         S_PIXELS: f_word = {1'b1, lo ? px[7:0] : px[15:8]};
         default:  f_word = 9'h000;
      endcase
   endfunction

   assign w_cur_word   = f_word(r_state, r_widx, r_lo, r_pix);
   assign w_next_word  = f_word(r_state, r_widx + 3'd1, 1'b0, r_pix);
   assign w_first_word = f_word(w_grp_next, 3'd0, 1'b0, r_pix);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_div        <= '0;
         r_phase      <= 1'b0;
         r_bit        <= '0;
         r_widx       <= '0;
         r_lo         <= 1'b0;
         r_gap        <= 1'b0;
         r_gcnt       <= '0;
         r_abort      <= 1'b0;
         r_pix        <= '0;
         r_have_pix   <= 1'b0;
         r_pix_ready  <= 1'b0;
         r_pix_cnt    <= '0;
         r_cs         <= 1'b1;
         r_sck        <= 1'b0;
         r_sda        <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_div        <= w_div_next;
         r_phase      <= w_phase_next;
         r_bit        <= w_bit_next;
         r_widx       <= w_widx_next;
         r_lo         <= w_lo_next;
         r_gap        <= w_gap_next;
         r_gcnt       <= w_gcnt_next;
         r_abort      <= w_abort_next;
         r_pix        <= w_pix_next;
         r_have_pix   <= w_have_pix_next;
         r_pix_ready  <= w_pix_ready_next;
         r_pix_cnt    <= w_pix_cnt_next;
         r_cs         <= w_cs_next;
         r_sck        <= w_sck_next;
         r_sda        <= w_sda_next;
         r_busy       <= w_busy_next;
         r_frame_done <= w_frame_done_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_div_next        = r_div;
      w_phase_next      = r_phase;
      w_bit_next        = r_bit;
      w_widx_next       = r_widx;
      w_lo_next         = r_lo;
      w_gap_next        = r_gap;
      w_gcnt_next       = r_gcnt;
      w_abort_next      = r_abort;
      w_pix_next        = r_pix;
      w_have_pix_next   = r_have_pix;
      w_pix_ready_next  = r_pix_ready;
      w_pix_cnt_next    = r_pix_cnt;
      w_cs_next         = r_cs;
      w_sck_next        = r_sck;
      w_sda_next        = r_sda;
      w_busy_next       = r_busy;
      w_frame_done_next = 1'b0;

      w_hs    = r_pix_ready & pix_valid;
      w_abort = r_abort | ~init_done;
      // Only the SCK rise of a pixel's D/C bit needs the pixel; everything else runs freely.
      w_wait  = (r_state == S_PIXELS) && !r_gap && !r_lo && (r_bit == 4'd8) &&
                !r_phase && !r_have_pix && !w_hs;

      case (r_state)
         S_CASET: w_grp_next = S_RASET;
         S_RASET: w_grp_next = S_RAMWR;
         default: w_grp_next = S_PIXELS;
      endcase

      case (r_state)
         S_IDLE: begin
            w_abort_next = 1'b0;
            if (frame_start && init_done) begin
               w_state_next    = S_CASET;
               w_busy_next     = 1'b1;
               w_cs_next       = 1'b0;
               w_sck_next      = 1'b0;
               w_sda_next      = 1'b0;
               w_div_next      = '0;
               w_phase_next    = 1'b0;
               w_bit_next      = 4'd8;
               w_widx_next     = '0;
               w_lo_next       = 1'b0;
               w_gap_next      = 1'b0;
               w_gcnt_next     = '0;
               w_pix_cnt_next  = '0;
               w_have_pix_next = 1'b0;
            end
         end

         S_GAP: begin
            w_pix_ready_next = 1'b0;
            if (r_gcnt == GAP_LAST) begin
               w_state_next = S_IDLE;
               w_busy_next  = 1'b0;
            end else begin
               w_gcnt_next = r_gcnt + 9'd1;
            end
         end

         default: begin
            if (!init_done) w_abort_next = 1'b1;
            if (r_gap) begin
               // CS held high for one SCK period between command groups.
               if (r_gcnt == GAP_LAST) begin
                  w_gap_next = 1'b0;
                  if (w_abort) begin
                     w_state_next = S_IDLE;
                     w_busy_next  = 1'b0;
                  end else begin
                     w_state_next    = w_grp_next;
                     w_cs_next       = 1'b0;
                     w_sck_next      = 1'b0;
                     w_sda_next      = w_first_word[8];
                     w_div_next      = '0;
                     w_phase_next    = 1'b0;
                     w_bit_next      = 4'd8;
                     w_widx_next     = '0;
                     w_lo_next       = 1'b0;
                     w_have_pix_next = 1'b0;
                     if (w_grp_next == S_PIXELS) w_pix_ready_next = 1'b1;
                  end
               end else begin
                  w_gcnt_next = r_gcnt + 9'd1;
               end
            end else if (w_wait && w_abort) begin
               w_pix_ready_next = 1'b0;
               w_cs_next        = 1'b1;
               w_sck_next       = 1'b0;
               w_sda_next       = 1'b0;
               w_gcnt_next      = '0;
               w_state_next     = S_GAP;
            end else begin
               if (w_hs) begin
                  w_pix_next       = pix_data;
                  w_have_pix_next  = 1'b1;
                  w_pix_ready_next = 1'b0;
                  w_pix_cnt_next   = r_pix_cnt + PCW'(1);
               end
               if (r_div != DIV_LAST) begin
                  w_div_next = r_div + 8'd1;
               end else if (!w_wait) begin
                  w_div_next = '0;
                  if (!r_phase) begin
                     w_phase_next = 1'b1;
                     w_sck_next   = 1'b1;
                  end else begin
                     w_phase_next = 1'b0;
                     w_sck_next   = 1'b0;
                     if (r_bit != 4'd0) begin
                        w_bit_next = r_bit - 4'd1;
                        w_sda_next = w_cur_word[r_bit - 4'd1];
                     end else if (w_abort) begin
                        w_cs_next    = 1'b1;
                        w_sda_next   = 1'b0;
                        w_gcnt_next  = '0;
                        w_state_next = S_GAP;
                     end else begin
                        case (r_state)
                           S_CASET, S_RASET: begin
                              if (r_widx == 3'd4) begin
                                 w_cs_next   = 1'b1;
                                 w_sda_next  = 1'b0;
                                 w_gap_next  = 1'b1;
                                 w_gcnt_next = '0;
                              end else begin
                                 w_widx_next = r_widx + 3'd1;
                                 w_bit_next  = 4'd8;
                                 w_sda_next  = w_next_word[8];
                              end
                           end
                           S_RAMWR: begin
                              w_cs_next   = 1'b1;
                              w_sda_next  = 1'b0;
                              w_gap_next  = 1'b1;
                              w_gcnt_next = '0;
                           end
                           default: begin
                              w_bit_next = 4'd8;
                              w_sda_next = 1'b1;
                              if (!r_lo) begin
                                 w_lo_next = 1'b1;
                              end else if (r_pix_cnt == PIX_LAST) begin
                                 w_cs_next         = 1'b1;
                                 w_sda_next        = 1'b0;
                                 w_frame_done_next = 1'b1;
                                 w_gcnt_next       = '0;
                                 w_state_next      = S_GAP;
                              end else begin
                                 w_lo_next        = 1'b0;
                                 w_have_pix_next  = 1'b0;
                                 w_pix_ready_next = 1'b1;
                              end
                           end
                        endcase
                     end
                  end
               end
            end
         end
      endcase
   end

   assign pix_ready  = r_pix_ready;
   assign LCD_SCK    = r_sck;
   assign LCD_CS     = r_cs;
   assign LCD_SDA    = r_sda;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_st7785_pixel_stream.sv
// Directed bench for st7785_pixel_stream: decodes the serial link on SCK rising
// edges and checks headers, pixels, stalls, gating, abort and async reset.
module tb_st7785_pixel_stream;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        init_done = 1'b0;
   logic        frame_start = 1'b0;
   logic        pix_valid = 1'b0;
   logic [15:0] pix_data;
   logic        pix_ready, LCD_SCK, LCD_CS, LCD_SDA, busy, frame_done;

   logic [15:0] pix_mem [4];
   int          hs_cnt = 0;
   int          hs_base = 0;
   assign pix_data = pix_mem[2'(hs_cnt - hs_base)];

   always #5 clk = ~clk;

   st7785_pixel_stream #(
      .CLK_DIV(2), .H_RES(2), .V_RES(2), .X_START(0), .Y_START(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .init_done(init_done), .frame_start(frame_start),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .LCD_SCK(LCD_SCK), .LCD_CS(LCD_CS), .LCD_SDA(LCD_SDA),
      .busy(busy), .frame_done(frame_done)
   );

   logic [8:0] exp_words [19] = '{
      9'h02A, 9'h100, 9'h100, 9'h100, 9'h101,
      9'h02B, 9'h100, 9'h100, 9'h100, 9'h101,
      9'h02C,
      9'h1F8, 9'h100, 9'h107, 9'h1E0, 9'h100, 9'h11F, 9'h1FF, 9'h1FF
   };

   int n_tests = 0;
   int n_fail  = 0;

   // Link monitor state
   logic [8:0] words [$];
   int         gaps [$];
   logic [8:0] sh = '0;
   int         nbits = 0, rises = 0, fd_cnt = 0, cs_falls = 0, cur_run = 0;
   int         sda_viol = 0, sck_cs_viol = 0;
   logic       prev_sck = 1'b0, prev_sda = 1'b0, prev_cs = 1'b1;

   initial forever begin
      @(posedge clk);
      if (reset_n && pix_ready && pix_valid) hs_cnt <= hs_cnt + 1;
   end

   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         nbits   = 0;
         cur_run = 0;
      end else begin
         if (LCD_CS) begin
            nbits = 0;
         end else if (LCD_SCK && !prev_sck) begin
            sh = {sh[7:0], LCD_SDA};
            nbits++;
            rises++;
            if (nbits == 9) begin
               words.push_back(sh);
               nbits = 0;
            end
         end
         if (prev_sck && LCD_SCK && (LCD_SDA !== prev_sda)) sda_viol++;
         if (LCD_CS && LCD_SCK) sck_cs_viol++;
         if (frame_done) fd_cnt++;
         if (prev_cs && !LCD_CS) begin
            cs_falls++;
            if (cur_run > 0) gaps.push_back(cur_run);
            cur_run = 0;
         end
         if (!busy) cur_run = 0;
         else if (LCD_CS) cur_run++;
      end
      prev_sck = LCD_SCK;
      prev_sda = LCD_SDA;
      prev_cs  = LCD_CS;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic start_frame;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!frame_done && n < 3000) begin
         tick;
         n++;
      end
   endtask

   task automatic busy_tail(output int n, output int pr);
      n  = 0;
      pr = 0;
      while (busy && n < 50) begin
         tick;
         n++;
         if (pix_ready) pr++;
      end
   endtask

   function automatic logic [31:0] word_at(input int i);
      return (i < words.size()) ? 32'(words[i]) : 32'hDEAD;
   endfunction

   task automatic check_frame(input int wb, input string tag);
      check({tag, "_count"}, words.size() - wb, 19);
      for (int i = 0; i < 19; i++) check(tag, word_at(wb + i), 32'(exp_words[i]));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, pr, wb, hb, rb, fb, cb, gb, bad, r0;
      pix_mem[0] = 16'hF800;
      pix_mem[1] = 16'h07E0;
      pix_mem[2] = 16'h001F;
      pix_mem[3] = 16'hFFFF;

      #2 reset_n = 1'b0;
      tick;
      tick;
      check("rst_cs", LCD_CS, 1);
      check("rst_sck", LCD_SCK, 0);
      check("rst_sda", LCD_SDA, 0);
      check("rst_ready", pix_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_fdone", frame_done, 0);
      reset_n = 1'b1;
      tick;
      tick;

      // frame_start without init_done must be ignored
      cb = cs_falls;
      start_frame;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy !== 1'b0 || LCD_CS !== 1'b1) bad++;
         tick;
      end
      check("gate_busy_cs", bad, 0);
      check("gate_cs_falls", cs_falls - cb, 0);

      // Full frame, pixels always valid, second frame_start mid-frame
      init_done = 1'b1;
      pix_valid = 1'b1;
      tick;
      wb = words.size(); hb = hs_cnt; hs_base = hs_cnt; rb = rises; fb = fd_cnt; gb = gaps.size();
      start_frame;
      check("accept_busy", busy, 1);
      check("accept_cs", LCD_CS, 0);
      check("accept_sck", LCD_SCK, 0);
      tick;
      check("sck_low1", LCD_SCK, 0);
      tick;
      check("sck_rise", LCD_SCK, 1);
      n = 2;
      while (!frame_done && n < 3000) begin
         tick;
         n++;
         if (n == 200) frame_start = 1'b1;
         else if (n == 201) frame_start = 1'b0;
      end
      check("f1_len", n, 696);
      busy_tail(n, pr);
      check("f1_tail", n, 4);
      for (int i = 0; i < 20; i++) tick;
      check("f1_busy_idle", busy, 0);
      check_frame(wb, "f1_word");
      check("f1_hs", hs_cnt - hb, 4);
      check("f1_fd", fd_cnt - fb, 1);
      check("f1_rises", rises - rb, 171);
      check("f1_ngaps", gaps.size() - gb, 3);
      for (int i = 0; i < 3; i++)
         check("f1_gap", (gb + i < gaps.size()) ? 32'(gaps[gb + i]) : 32'hDEAD, 4);

      // Stall before pixel 3
      wb = words.size(); hb = hs_cnt; hs_base = hs_cnt; fb = fd_cnt;
      start_frame;
      n = 0;
      while (hs_cnt - hb < 2 && n < 3000) begin tick; n++; end
      pix_valid = 1'b0;
      n = 0;
      while (!pix_ready && n < 3000) begin tick; n++; end
      check("stall_ready_seen", pix_ready, 1);
      r0 = rises;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick;
         if (LCD_SCK !== 1'b0 || LCD_CS !== 1'b0 || pix_ready !== 1'b1) bad++;
      end
      check("stall_hold", bad, 0);
      check("stall_no_sck", rises - r0, 0);
      check("stall_hs", hs_cnt - hb, 2);
      pix_valid = 1'b1;
      wait_done(n);
      check("stall_fd_seen", frame_done, 1);
      busy_tail(n, pr);
      check("stall_tail", n, 4);
      check_frame(wb, "stall_word");
      check("stall_hs_total", hs_cnt - hb, 4);
      check("stall_fd", fd_cnt - fb, 1);

      // Abort during 2nd bit of pixel word 5
      tick;
      wb = words.size(); hb = hs_cnt; hs_base = hs_cnt; rb = rises; fb = fd_cnt;
      start_frame;
      n = 0;
      while (!(words.size() == wb + 15 && nbits == 1) && n < 3000) begin tick; n++; end
      check("abort_reached", words.size() - wb, 15);
      init_done = 1'b0;
      n = 0;
      while (!LCD_CS && n < 200) begin tick; n++; end
      check("abort_cs", LCD_CS, 1);
      check("abort_words", words.size() - wb, 16);
      check("abort_last", word_at(wb + 15), 32'h100);
      check("abort_rises", rises - rb, 144);
      busy_tail(n, pr);
      check("abort_tail", n, 4);
      check("abort_no_ready", pr, 0);
      check("abort_no_fd", fd_cnt - fb, 0);
      init_done = 1'b1;
      tick;

      // Async reset mid-RASET, then a clean frame
      wb = words.size(); hs_base = hs_cnt;
      start_frame;
      n = 0;
      while (!(words.size() == wb + 6 && nbits == 1) && n < 3000) begin tick; n++; end
      check("arst_reached", words.size() - wb, 6);
      reset_n = 1'b0;
      #1;
      check("arst_cs", LCD_CS, 1);
      check("arst_sck", LCD_SCK, 0);
      check("arst_sda", LCD_SDA, 0);
      check("arst_busy", busy, 0);
      tick;
      tick;
      reset_n = 1'b1;
      tick;
      wb = words.size(); hb = hs_cnt; hs_base = hs_cnt; fb = fd_cnt;
      start_frame;
      wait_done(n);
      check("rf_len", n, 696);
      busy_tail(n, pr);
      check("rf_tail", n, 4);
      check_frame(wb, "rf_word");
      check("rf_hs", hs_cnt - hb, 4);
      check("rf_fd", fd_cnt - fb, 1);

      check("sda_stable_sck_high", sda_viol, 0);
      check("sck_low_when_cs_high", sck_cs_viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
